// File: rtl/dma_bus_arbiter_pkg.sv
// dma_bus_arbiter_pkg: state encoding and default DMA command fields shared by
// the arbiter, its interface and the CPU top.
package dma_bus_arbiter_pkg;
    localparam int ADDR_W = 16;
    localparam logic [ADDR_W-1:0] DMA_ADDR_DEF = 16'h01F4;
    localparam logic [ADDR_W-1:0] DMA_LEN_DEF  = 16'd12;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_BR,
        S_DRAIN,
        S_GNT
    } state_t;
endpackage

// File: rtl/dma_bus_arbiter_if.sv
// dma_bus_arbiter_if: DMA handshake and CPU d-side stall signals around the arbiter.
interface dma_bus_arbiter_if #(
    parameter int GNT_CNT_W = 16
);
    import dma_bus_arbiter_pkg::*;
    logic                 dma_begin;
    logic                 dma_end;
    logic                 br;
    logic                 cpu_mem_busy;
    logic                 cpu_d_req;
    logic                 bg;
    logic                 cmd;
    logic [ADDR_W-1:0]    dma_address;
    logic [ADDR_W-1:0]    dma_length;
    logic                 cpu_stall;
    logic [GNT_CNT_W-1:0] grant_cycles;
    modport master (
        input  dma_begin, dma_end, br, cpu_mem_busy, cpu_d_req,
        output bg, cmd, dma_address, dma_length, cpu_stall, grant_cycles
    );
    modport slave (
        output dma_begin, dma_end, br, cpu_mem_busy, cpu_d_req,
        input  bg, cmd, dma_address, dma_length, cpu_stall, grant_cycles
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: issues the DMA command on a DMA_begin edge and hands the data bus to
// the DMA controller only between CPU memory accesses, stalling the CPU d-side meanwhile.
module dma_bus_arbiter
    import dma_bus_arbiter_pkg::*;
#(
    parameter logic [ADDR_W-1:0] DMA_ADDR   = DMA_ADDR_DEF,
    parameter logic [ADDR_W-1:0] DMA_LEN    = DMA_LEN_DEF,
    parameter int                CMD_CYCLES = 1,
    parameter int                GNT_CNT_W  = 16
) (
    input logic               clk,
    input logic               rst_n,
    dma_bus_arbiter_if.master bus
);
    localparam int CW = $clog2(CMD_CYCLES + 1);

    state_t               state;
    state_t               next_state;
    logic                 begin_q;
    logic                 pending;
    logic                 begin_edge;
    logic                 cmd_done;
    logic [CW-1:0]        cmd_cnt;
    logic [GNT_CNT_W-1:0] grant_cnt;

    assign begin_edge       = bus.dma_begin & ~begin_q;
    assign cmd_done         = cmd_cnt == CW'(CMD_CYCLES - 1);
    assign bus.grant_cycles = grant_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            begin_q   <= 1'b0;
            pending   <= 1'b0;
            cmd_cnt   <= '0;
            grant_cnt <= '0;
        end else begin
            state   <= next_state;
            begin_q <= bus.dma_begin;
            // one request can queue behind the running transfer; IDLE always consumes it
            pending <= (state == S_IDLE) ? 1'b0 : pending | begin_edge;
            cmd_cnt <= (state == S_CMD) ? cmd_cnt + 1'b1 : '0;
            if (next_state == S_CMD && state != S_CMD)
                grant_cnt <= '0;
            else if (state == S_GNT && !(&grant_cnt))
                grant_cnt <= grant_cnt + 1'b1;
        end
    end

    always_comb begin
        next_state      = state;
        bus.bg          = state == S_GNT;
        bus.cmd         = state == S_CMD;
        bus.dma_address = (state == S_CMD) ? DMA_ADDR : '0;
        bus.dma_length  = (state == S_CMD) ? DMA_LEN : '0;
        // combinational so the cache cannot launch a fill in the cycle BG is about to rise
        bus.cpu_stall   = (state == S_DRAIN || state == S_GNT) && bus.cpu_d_req;
        unique case (state)
            S_IDLE:             next_state = (begin_edge || pending) ? S_CMD : S_IDLE;
            S_CMD:              next_state = cmd_done ? S_WAIT_BR : S_CMD;
            S_WAIT_BR, S_DRAIN: next_state = bus.dma_end ? S_IDLE :
                                             !bus.br ? S_WAIT_BR :
                                             bus.cpu_mem_busy ? S_DRAIN : S_GNT;
            S_GNT:              next_state = bus.dma_end ? S_IDLE : bus.br ? S_GNT : S_WAIT_BR;
            default:            next_state = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// tb_dma_bus_arbiter: directed vector table plus hand-written multi-cycle sequences
// for the DMA bus arbiter.
module tb_dma_bus_arbiter;
    typedef struct packed {
        logic [4:0]  in;
        logic [2:0]  xo;
        logic [15:0] gc;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    dma_bus_arbiter_if #(.GNT_CNT_W(16)) bus ();
    dma_bus_arbiter #(.GNT_CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // xo = {bg, cmd, cpu_stall}; address/length must follow cmd
    task automatic expect_out(input string tag, input logic [2:0] xo, input logic [15:0] gc);
        check({tag, " bg"}, 16'(bus.bg), 16'(xo[2]));
        check({tag, " cmd"}, 16'(bus.cmd), 16'(xo[1]));
        check({tag, " stall"}, 16'(bus.cpu_stall), 16'(xo[0]));
        check({tag, " addr"}, bus.dma_address, xo[1] ? 16'h01F4 : 16'h0000);
        check({tag, " len"}, bus.dma_length, xo[1] ? 16'd12 : 16'd0);
        check({tag, " gc"}, bus.grant_cycles, gc);
    endtask

    // in = {dma_begin, dma_end, br, cpu_mem_busy, cpu_d_req}
    task automatic step(input string tag, input logic [4:0] in, input logic [2:0] xo,
                        input logic [15:0] gc);
        {bus.dma_begin, bus.dma_end, bus.br, bus.cpu_mem_busy, bus.cpu_d_req} = in;
        @(posedge clk);
        #1;
        expect_out(tag, xo, gc);
    endtask

    initial begin
        rst_n = 1'b0;
        {bus.dma_begin, bus.dma_end, bus.br, bus.cpu_mem_busy, bus.cpu_d_req} = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 3'b000, 16'd0);
        rst_n = 1'b1;

        // BR ignored in IDLE, DMA_end+BR in WAIT_BR, drain then grant, short steal
        tbl.push_back(vec_t'{5'b00101, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b10001, 3'b010, 16'd0});
        tbl.push_back(vec_t'{5'b10001, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b11101, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b10100, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b00000, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b10000, 3'b010, 16'd0});
        tbl.push_back(vec_t'{5'b00000, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b00111, 3'b001, 16'd0});
        tbl.push_back(vec_t'{5'b00110, 3'b000, 16'd0});
        tbl.push_back(vec_t'{5'b00111, 3'b001, 16'd0});
        tbl.push_back(vec_t'{5'b00101, 3'b101, 16'd0});
        tbl.push_back(vec_t'{5'b00100, 3'b100, 16'd1});
        tbl.push_back(vec_t'{5'b00001, 3'b000, 16'd2});
        tbl.push_back(vec_t'{5'b00100, 3'b100, 16'd2});
        tbl.push_back(vec_t'{5'b01100, 3'b000, 16'd3});
        tbl.push_back(vec_t'{5'b00000, 3'b000, 16'd3});
        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].xo, tbl[i].gc);

        // full transfer: cmd clears the old count, twelve grant cycles
        step("t2 cmd", 5'b10000, 3'b010, 16'd0);
        step("t2 wait", 5'b00000, 3'b000, 16'd0);
        step("t2 gnt", 5'b00100, 3'b100, 16'd0);
        for (int i = 1; i <= 11; i++) step($sformatf("t2 gc%0d", i), 5'b00100, 3'b100, 16'(i));
        step("t2 end", 5'b01100, 3'b000, 16'd12);
        step("t2 idle", 5'b00000, 3'b000, 16'd12);

        // cycle stealing with CPU requesting throughout
        step("t4 cmd", 5'b10001, 3'b010, 16'd0);
        step("t4 wait", 5'b00001, 3'b000, 16'd0);
        step("t4 gnt", 5'b00101, 3'b101, 16'd0);
        step("t4 gnt1", 5'b00101, 3'b101, 16'd1);
        step("t4 steal", 5'b00001, 3'b000, 16'd2);
        for (int i = 0; i < 3; i++) step($sformatf("t4 low%0d", i), 5'b00001, 3'b000, 16'd2);
        step("t4 regnt", 5'b00101, 3'b101, 16'd2);
        step("t4 resume", 5'b00101, 3'b101, 16'd3);
        step("t4 end", 5'b01100, 3'b000, 16'd4);

        // pending request served exactly once
        step("t5 cmd1", 5'b10000, 3'b010, 16'd0);
        step("t5 wait", 5'b00000, 3'b000, 16'd0);
        step("t5 gnt", 5'b00100, 3'b100, 16'd0);
        step("t5 edge1", 5'b10100, 3'b100, 16'd1);
        step("t5 low", 5'b00100, 3'b100, 16'd2);
        step("t5 edge2", 5'b10100, 3'b100, 16'd3);
        step("t5 end", 5'b01100, 3'b000, 16'd4);
        step("t5 cmd2", 5'b00000, 3'b010, 16'd0);
        step("t5 wait2", 5'b00000, 3'b000, 16'd0);
        step("t5 end2", 5'b01000, 3'b000, 16'd0);
        for (int i = 0; i < 3; i++) step($sformatf("t5 nocmd%0d", i), 5'b00000, 3'b000, 16'd0);

        // begin edge and DMA_end together in GNT
        step("t5b cmd", 5'b10000, 3'b010, 16'd0);
        step("t5b wait", 5'b00000, 3'b000, 16'd0);
        step("t5b gnt", 5'b00100, 3'b100, 16'd0);
        step("t5b both", 5'b11100, 3'b000, 16'd1);
        step("t5b cmd2", 5'b10000, 3'b010, 16'd0);
        step("t5b wait2", 5'b00000, 3'b000, 16'd0);
        step("t5b end", 5'b01000, 3'b000, 16'd0);
        step("t5b nocmd", 5'b00000, 3'b000, 16'd0);

        // asynchronous reset in the middle of a grant
        step("t1 cmd", 5'b10001, 3'b010, 16'd0);
        step("t1 wait", 5'b00001, 3'b000, 16'd0);
        step("t1 gnt", 5'b00101, 3'b101, 16'd0);
        step("t1 gnt1", 5'b00101, 3'b101, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("t1 async", 3'b000, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("t1 idle", 5'b00101, 3'b000, 16'd0);
        step("t1 cmd2", 5'b10101, 3'b010, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
